// File: rtl/dec3to8_dual_pkg.sv
// rtl/dec3to8_dual_pkg.sv - shared widths, one-hot type and decode style enum
package dec_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 2 ** IN_W;

  typedef logic [OUT_W-1:0] onehot_t;

  typedef enum logic {
    DEC_SHIFT = 1'b0,
    DEC_CASE  = 1'b1
  } dec_style_e;

endpackage

// File: rtl/dec3to8_dual_if.sv
// rtl/dec3to8_dual_if.sv - select inputs and decoded outputs bundle
interface dec3to8_dual_if;
  import dec_pkg::*;

  logic [IN_W-1:0] in;
  logic            en;
  onehot_t         d_shift;
  onehot_t         d_case;
  logic            mismatch;

  modport master (
    output in,
    output en,
    input  d_shift,
    input  d_case,
    input  mismatch
  );

  modport slave (
    input  in,
    input  en,
    output d_shift,
    output d_case,
    output mismatch
  );

endinterface

// File: rtl/dec3to8_dual_core.sv
// rtl/dec3to8_dual_core.sv - combinational 3-to-8 decoder, shift or table style
module dec3to8_core
  import dec_pkg::*;
#(
  parameter dec_style_e STYLE = DEC_SHIFT
) (
  input  logic [IN_W-1:0] in,
  input  logic            en,
  output onehot_t         out
);

  generate
    if (STYLE == DEC_SHIFT) begin : g_shift
      // Shift at full output width so every 3-bit code lands inside the vector
      always_comb begin
        out = '0;
        if (en) begin
          out = onehot_t'(1) << in;
        end
      end
    end else begin : g_case
      // Explicit table; unknown selects fall to the default so they disagree with the shift path
      always_comb begin
        out = '0;
        if (en) begin
          case (in)
            3'd0:    out = 8'h01;
            3'd1:    out = 8'h02;
            3'd2:    out = 8'h04;
            3'd3:    out = 8'h08;
            3'd4:    out = 8'h10;
            3'd5:    out = 8'h20;
            3'd6:    out = 8'h40;
            3'd7:    out = 8'h80;
            default: out = 8'h00;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dec3to8_dual.sv
// rtl/dec3to8_dual.sv - registered dual-implementation decoder with disagreement flag
module dec3to8_dual
  import dec_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  dec3to8_dual_if.slave      bus
);

  onehot_t w_shift;
  onehot_t w_case;
  logic    w_diff;

  onehot_t r_shift;
  onehot_t r_case;
  logic    r_mismatch;

  dec3to8_core #(.STYLE(DEC_SHIFT)) u_shift (
    .in  (bus.in),
    .en  (bus.en),
    .out (w_shift)
  );

  dec3to8_core #(.STYLE(DEC_CASE)) u_case (
    .in  (bus.in),
    .en  (bus.en),
    .out (w_case)
  );

  assign w_diff = (w_shift != w_case);

  // Capture both decodes and their comparison on the same edge so the flag lines up with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_case     <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_shift    <= w_shift;
      r_case     <= w_case;
      r_mismatch <= w_diff;
    end
  end

  assign bus.d_shift  = r_shift;
  assign bus.d_case   = r_case;
  assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_dec3to8_dual.sv
// tb/tb_dec3to8_dual.sv - self-checking bench for dec3to8_dual
module tb_dec3to8_dual;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [7:0] exp_s;
  logic [7:0] exp_c;
  logic       exp_m;

  dec3to8_dual_if bus ();

  dec3to8_dual dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an enabled code n selects the output bit worth 2**n
  function automatic logic [7:0] model(input int code, input logic e);
    int v;
    v = 1;
    if (!e) return 8'h00;
    for (int i = 0; i < code; i++) v = v * 2;
    return v[7:0];
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk8({tag, ".d_shift"}, bus.d_shift, exp_s);
    chk8({tag, ".d_case"}, bus.d_case, exp_c);
    chk1({tag, ".mismatch"}, bus.mismatch, exp_m);
  endtask

  // Apply a code just after an edge, confirm outputs hold until the next edge, then check the new result
  task automatic step(input string tag, input int code, input logic e);
    bus.in = code[2:0];
    bus.en = e;
    #1;
    chk_all({tag, ".hold"});
    @(posedge clk);
    #1;
    exp_s = model(code, e);
    exp_c = exp_s;
    exp_m = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_s    = 8'h00;
    exp_c    = 8'h00;
    exp_m    = 1'b0;
    rst_n    = 1'b1;
    bus.in   = 3'b101;
    bus.en   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("reset_async");

    // Held in reset with live inputs
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all("reset_hold");
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_s = 8'h20; exp_c = 8'h20; exp_m = 1'b0;
    chk_all("reset_release");

    for (int i = 0; i < 8; i++) step("dis_sweep", i, 1'b0);
    for (int i = 0; i < 8; i++) step("en_sweep", i, 1'b1);

    step("en_toggle1", 3, 1'b1);
    step("en_toggle0", 3, 1'b0);
    step("en_toggle2", 3, 1'b1);

    // Async reset between edges
    step("pre_reset", 7, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_s = 8'h00; exp_c = 8'h00; exp_m = 1'b0;
    chk_all("mid_reset");
    @(posedge clk);
    #1;
    chk_all("mid_reset_edge");
    rst_n = 1'b1;
    step("post_reset", 7, 1'b1);

    // Corrupt the table path to prove the comparator flags disagreement
    step("pre_force", 2, 1'b1);
    force dut.w_case = 8'h00;
    #1;
    chk_all("force_hold");
    @(posedge clk);
    #1;
    exp_s = 8'h04; exp_c = 8'h00; exp_m = 1'b1;
    chk_all("forced");
    release dut.w_case;
    @(posedge clk);
    #1;
    exp_s = 8'h04; exp_c = 8'h04; exp_m = 1'b0;
    chk_all("released");

    // Random back-to-back codes
    for (int n = 0; n < 200; n++) begin
      step("random", int'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
